// File: rtl/mux_gate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_gate_arbiter
//  Description : Shares one mux-built bitwise gate unit (AND/OR/NAND/NOR/
//                XOR/XNOR) between N_REQ requesters. Round-robin arbitration
//                with a valid/ready request handshake and a single response
//                channel tagged with the requester ID.
//  Ports       : clk, rst              clock, synchronous active-high reset
//                req_valid/req_ready   per-requester request handshake
//                req_a/req_b/req_op    packed operands/opcodes, requester i at
//                                      [i*WIDTH +: WIDTH] / [i*3 +: 3]
//                rsp_valid/rsp_ready   response handshake
//                rsp_id/rsp_data/rsp_err  response payload
//  Config      : MUX_GATE_ARB_FIXED_PRIO_EN - when defined, lowest index
//                always wins and the round-robin pointer is removed.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_gate_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*3-1:0]     req_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [2:0]        r_op;
    logic [ID_W-1:0]   r_id;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [WIDTH-1:0]  r_rsp_data;
    logic              r_rsp_err;

    logic [ID_W-1:0]   w_start;
    logic              w_any;
    logic [ID_W-1:0]   w_win;
    logic [WIDTH-1:0]  w_and;
    logic [WIDTH-1:0]  w_or;
    logic [WIDTH-1:0]  w_xor;
    logic [WIDTH-1:0]  w_res;
    logic              w_err;

    // Requester index at offset k from the search start, wrapping at N_REQ.
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] start, input int k);
        int s;
        s = int'(start) + k;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return s[ID_W-1:0];
    endfunction

`ifdef MUX_GATE_ARB_FIXED_PRIO_EN
    assign w_start = '0;
`else
    logic [ID_W-1:0] r_ptr;
    assign w_start = r_ptr;
`endif

    // First valid requester found walking forward from the search start.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_any && req_valid[rr_idx(w_start, k)]) begin
                w_any = 1'b1;
                w_win = rr_idx(w_start, k);
            end
        end
    end

    // Grant is only offered in IDLE and never while reset is being applied,
    // so a request seen during the reset cycle is not consumed.
    always_comb begin
        req_ready = '0;
        if ((r_state == S_IDLE) && !rst && w_any) begin
            req_ready[w_win] = 1'b1;
        end
    end

    // Gate unit: every bit is a 2:1 mux steered by b; inverted forms follow.
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            w_and[k] = r_b[k] ? r_a[k]  : 1'b0;
            w_or[k]  = r_b[k] ? 1'b1    : r_a[k];
            w_xor[k] = r_b[k] ? ~r_a[k] : r_a[k];
        end
    end

    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (r_op)
            3'd0:    w_res = w_and;
            3'd1:    w_res = w_or;
            3'd2:    w_res = ~w_and;
            3'd3:    w_res = ~w_or;
            3'd4:    w_res = w_xor;
            3'd5:    w_res = ~w_xor;
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
`ifndef MUX_GATE_ARB_FIXED_PRIO_EN
            r_ptr       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_a     <= req_a[int'(w_win)*WIDTH +: WIDTH];
                        r_b     <= req_b[int'(w_win)*WIDTH +: WIDTH];
                        r_op    <= req_op[int'(w_win)*3 +: 3];
                        r_id    <= w_win;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_rsp_data  <= w_res;
                    r_rsp_err   <= w_err;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
`ifndef MUX_GATE_ARB_FIXED_PRIO_EN
                        // Search resumes just after the requester just served.
                        r_ptr       <= (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_gate_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_gate_arbiter
//  Description : Self-checking bench for mux_gate_arbiter. Grants are
//                predicted by a reference arbiter; expected responses are
//                queued at grant time and compared by a response monitor.
//                Honours MUX_GATE_ARB_FIXED_PRIO_EN for the expected order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_gate_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N*3-1:0] req_op;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;

    mux_gate_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int kat_op = 0;

    typedef struct {
        int       id;
        logic [W-1:0] data;
        logic     err;
    } rsp_t;
    rsp_t sb[$];

    int m_ptr   = 0;   // where the reference arbiter starts searching
    int m_phase = 0;   // 0 waiting for grant, 1 computing, 2 response offered

    function automatic logic [W-1:0] gate_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arbiter: predicts req_ready and rsp_valid, queues responses.
    always @(negedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_ptr   = 0;
            sb.delete();
        end else begin
            int           win;
            int           idx;
            logic [N-1:0] exp_ready;
            rsp_t         e;
            win       = -1;
            exp_ready = '0;
            if (m_phase == 0) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (win < 0 && req_valid[idx]) win = idx;
                end
            end
            if (win >= 0) exp_ready[win] = 1'b1;
            check("req_ready", req_ready, exp_ready);
            check("rsp_valid", rsp_valid, m_phase == 2);
            case (m_phase)
                0: if (win >= 0) begin
                    e.id   = win;
                    e.data = gate_ref(req_op[win*3 +: 3], req_a[win*W +: W], req_b[win*W +: W]);
                    e.err  = (req_op[win*3 +: 3] > 3'd5);
                    sb.push_back(e);
`ifndef MUX_GATE_ARB_FIXED_PRIO_EN
                    m_ptr = (win + 1) % N;
`endif
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: if (rsp_ready) m_phase = 0;
            endcase
        end
    end

    // Response monitor: payload must match the queue head for every cycle
    // it is offered; popped on handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                check("rsp_id",   rsp_id,   sb[0].id);
                check("rsp_data", rsp_data, sb[0].data);
                check("rsp_err",  rsp_err,  sb[0].err);
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_op[i*3 +: 3] = op;
        req_valid[i]     = 1'b1;
    endtask

    task automatic new_req(input int i, input bit kat);
        if (kat) begin
            set_req(i, 8'hF0, 8'hCC, 3'(kat_op % 6));
            kat_op++;
        end else begin
            set_req(i, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic single(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        bit got;
        got = 1'b0;
        set_req(i, a, b, op);
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
            @(posedge clk); #1;
        end
        req_valid[i] = 1'b0;
        if (!got) check("grant_timeout", req_ready[i], 1'b1);
    endtask

    task automatic wait_idle();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int cycles, input bit kat, input bit allv, input int rdy_pct);
        logic [N-1:0] gr;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            gr = req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (gr[i]) begin
                    if (allv || $urandom_range(0, 1) == 1) new_req(i, kat);
                    else req_valid[i] = 1'b0;
                end else if (!req_valid[i] && (allv || $urandom_range(0, 99) < 30)) begin
                    new_req(i, kat);
                end
            end
            rsp_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = '1;
        repeat (2) begin
            @(negedge clk);
            check("reset_req_ready", req_ready, '0);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_data",  rsp_data,  '0);
        check("reset_rsp_id",    rsp_id,    '0);
        check("reset_rsp_err",   rsp_err,   1'b0);
        @(posedge clk); #1;

        // Basic AND from requester 0
        rsp_ready = 1'b1;
        single(0, 8'hF0, 8'hCC, 3'd0);
        wait_idle();

        // All opcodes on F0/CC with all requesters contending
        drive(40, 1'b1, 1'b1, 100);
        wait_idle();

        // Illegal opcode from requester 2
        single(2, 8'hA5, 8'h5A, 3'd6);
        wait_idle();

        // Response held while consumer stalls; others waiting meanwhile
        rsp_ready = 1'b0;
        single(1, 8'h3C, 8'h0F, 3'd4);
        for (int i = 0; i < N; i++) new_req(i, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drive(20, 1'b0, 1'b0, 100);
        wait_idle();

        // Reset asserted while an operation is executing
        single(3, 8'hFF, 8'h0F, 3'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midop_rsp_valid", rsp_valid, 1'b0);
        check("midop_rsp_data",  rsp_data,  '0);
        check("midop_rsp_id",    rsp_id,    '0);
        check("midop_rsp_err",   rsp_err,   1'b0);
        check("midop_req_ready", req_ready, '0);
        @(posedge clk); #1;
        single(2, 8'h81, 8'h18, 3'd5);
        wait_idle();

        // Random traffic with random back-pressure
        drive(400, 1'b0, 1'b0, 60);

        // Drain
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int t = 0; t < 30 && (sb.size() != 0 || m_phase != 0); t++) @(posedge clk);
        check("drain_outstanding", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
